// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern arbiter.
// The GAP state exists only when LED_ARB_GAP_EN is defined.
package led_pkg;

   localparam int N_DEFAULT = 24;

   localparam logic [1:0] PAT_SOLID  = 2'b00;
   localparam logic [1:0] PAT_SLOW   = 2'b01;
   localparam logic [1:0] PAT_FAST   = 2'b10;
   localparam logic [1:0] PAT_DOUBLE = 2'b11;

`ifdef LED_ARB_GAP_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1} state_t;
`endif

   // hi = prescaler MSB, lo = prescaler bit two below it
   function automatic logic pat_led(input logic [1:0] code, input logic hi, input logic lo);
      case (code)
         PAT_SOLID:  return 1'b1;
         PAT_SLOW:   return hi;
         PAT_FAST:   return lo;
         PAT_DOUBLE: return ~hi & lo;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant
);

   always_comb begin
      grant = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NREQ;
         if (grant == '0 && req[idx]) grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/led_pattern_arb.sv
// Shares one LED among NREQ requesters; each grant plays REPS pattern periods.
// Define LED_ARB_GAP_EN to insert one dark period between grants.
module led_pattern_arb
   import led_pkg::*;
#(
   parameter int N    = N_DEFAULT,
   parameter int NREQ = 4,
   parameter int REPS = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] pat,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              LED
);

   localparam int         IW       = $clog2(NREQ);
   localparam logic [3:0] LAST_REP = 4'(REPS - 1);

   state_t          state, state_n;
   logic [N:0]      cnt, cnt_n;
   logic [3:0]      rep, rep_n;
   logic [IW-1:0]   ptr, ptr_n, gidx, gidx_n, sel_idx;
   logic [1:0]      code, code_n;
   logic [NREQ-1:0] sel, gnt_n, done_n;
   logic            led_n, wrap;

   assign wrap = &cnt;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req),
      .ptr   (ptr),
      .grant (sel)
   );

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (sel[i]) sel_idx = IW'(i);
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      rep_n   = rep;
      ptr_n   = ptr;
      gidx_n  = gidx;
      code_n  = code;
      gnt_n   = gnt;
      done_n  = '0;
      case (state)
         // Skip arbitration in the done cycle so a finishing requester can drop req
         S_IDLE: if (|sel && !(|done)) begin
            state_n = S_PLAY;
            cnt_n   = '0;
            rep_n   = '0;
            gidx_n  = sel_idx;
            ptr_n   = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
            code_n  = pat[2*int'(sel_idx) +: 2];
            gnt_n   = sel;
         end
         S_PLAY: begin
            if (!req[gidx] || (wrap && rep == LAST_REP)) begin
               done_n = gnt;
               gnt_n  = '0;
`ifdef LED_ARB_GAP_EN
               state_n = S_GAP;
               cnt_n   = '0;
`else
               state_n = S_IDLE;
`endif
            end else if (wrap) begin
               rep_n = rep + 1'b1;
            end
         end
`ifdef LED_ARB_GAP_EN
         S_GAP: if (wrap) state_n = S_IDLE;
`endif
         default: state_n = S_IDLE;
      endcase
      // Decode from next-state values so LED lines up with gnt and cnt
      led_n = (state_n == S_PLAY) ? pat_led(code_n, cnt_n[N], cnt_n[N-2]) : 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         cnt   <= '0;
         rep   <= '0;
         ptr   <= '0;
         gidx  <= '0;
         code  <= PAT_SOLID;
         gnt   <= '0;
         done  <= '0;
         LED   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         rep   <= rep_n;
         ptr   <= ptr_n;
         gidx  <= gidx_n;
         code  <= code_n;
         gnt   <= gnt_n;
         done  <= done_n;
         LED   <= led_n;
      end
   end

endmodule

// File: tb/tb_led_pattern_arb.sv
// Bench for led_pattern_arb (N=3, NREQ=4, REPS=2): timeline model plus directed scenarios.
module tb_led_pattern_arb;

   localparam int N = 3, NREQ = 4, REPS = 2, PER = 16;
`ifdef LED_ARB_GAP_EN
   localparam int GAPC = PER;
`else
   localparam int GAPC = 1;
`endif

   logic       clk = 1'b0, resetn = 1'b1;
   logic [3:0] req = '0;
   logic [7:0] pat = '0;
   logic [3:0] gnt, done;
   logic       LED;
   int         checks = 0, fails = 0;

   always #5 clk = ~clk;

   led_pattern_arb #(.N(N), .NREQ(NREQ), .REPS(REPS)) dut (
      .clk(clk), .resetn(resetn), .req(req), .pat(pat),
      .gnt(gnt), .done(done), .LED(LED)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic led_of(input logic [1:0] c, input int ph);
      logic [3:0] p;
      p = 4'(ph);
      case (c)
         2'b00:   return 1'b1;
         2'b01:   return p[3];
         2'b10:   return p[1];
         default: return ~p[3] & p[1];
      endcase
   endfunction

   // Model: owner index, cycles played, and a cooldown before the next arbitration
   int         own = -1, t = 0, last = NREQ - 1, wait_c = 0;
   logic [1:0] mpat = '0;
   logic [3:0] e_gnt = '0, e_done = '0;
   logic       e_led = 1'b0;

   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         own = -1; t = 0; last = NREQ - 1; wait_c = 0;
         e_gnt = '0; e_done = '0; e_led = 1'b0;
      end else begin
         e_done = '0;
         if (own >= 0) begin
            if (!req[own] || t == REPS*PER - 1) begin
               e_done[own] = 1'b1;
               own = -1;
               wait_c = GAPC;
            end else t++;
         end else if (wait_c > 0) begin
            wait_c--;
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               int i;
               i = (last + k) % NREQ;
               if (own < 0 && req[i]) begin
                  own = i; last = i; t = 0; mpat = pat[2*i +: 2];
               end
            end
         end
         e_gnt = (own >= 0) ? 4'(1 << own) : 4'b0;
         e_led = (own >= 0) ? led_of(mpat, t % PER) : 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("gnt", int'(gnt), int'(e_gnt));
      chk("done", int'(done), int'(e_done));
      chk("led", int'(LED), int'(e_led));
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_grant(input int maxc, output logic [3:0] g);
      int n = 0;
      while (gnt == 4'b0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("grant_seen", int'(gnt != 4'b0), 1);
      g = gnt;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g, prev;
      logic       pl;
      int         n, lastn, tog, hi, lowc;
      logic [3:0] rr_exp [4];
      logic [1:0] codes [3];
      int         hi_exp [3];
      rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      codes  = '{2'b00, 2'b10, 2'b11};
      hi_exp = '{16, 8, 4};

      // Reset with everyone requesting
      #1 resetn = 1'b0;
      req = 4'b1111;
      repeat (5) begin
         @(negedge clk);
         chk("rst_gnt", int'(gnt), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_led", int'(LED), 0);
      end
      resetn = 1'b1;
      wait_grant(10, g);
      chk("first_gnt", int'(g), 1);
      req = 4'b0;
      @(negedge clk);
      chk("rst_abort_done", int'(done), 1);
      idle(22);

      // Single full play, slow blink
      req = 4'b0100;
      pat = 8'b0001_0000;
      wait_grant(60, g);
      chk("single_gnt", int'(g), 4);
      chk("single_led0", int'(LED), 0);
      n = 0; lastn = 0; tog = 0; pl = LED;
      while (gnt == 4'b0100 && n < 40) begin
         @(negedge clk);
         n++;
         if (gnt == 4'b0100 && LED != pl) begin
            tog++;
            chk("single_tog_gap", n - lastn, 8);
            lastn = n;
         end
         pl = LED;
      end
      chk("single_len", n, 32);
      chk("single_tog", tog, 3);
      chk("single_done", int'(done), 4);
      req = 4'b0;
      @(negedge clk);
      chk("single_done_pulse", int'(done), 0);
      idle(22);

      // Reset mid-play, then round-robin from a fresh pointer
      req = 4'b0100;
      pat = 8'b0;
      wait_grant(60, g);
      idle(5);
      #2 resetn = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_done", int'(done), 0);
         chk("midrst_gnt", int'(gnt), 0);
      end
      req = 4'b1011;
      resetn = 1'b1;
      prev = 4'b0;
      for (int k = 0; k < 4; k++) begin
         wait_grant(60, g);
         chk("rr_order", int'(g), int'(rr_exp[k]));
         chk("rr_repeat", int'(g == prev), 0);
         prev = g;
         n = 0;
         while (gnt == g && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("rr_done", int'(done), int'(g));
      end
      req = 4'b0;
      idle(22);

      // Abort five cycles into play
      req = 4'b0010;
      pat = 8'b0000_1000;
      wait_grant(60, g);
      chk("abort_gnt", int'(g), 2);
      idle(5);
      req = 4'b0;
      @(negedge clk);
      chk("abort_done", int'(done), 2);
      chk("abort_gnt_off", int'(gnt), 0);
      chk("abort_led", int'(LED), 0);
      @(negedge clk);
      chk("abort_done_once", int'(done), 0);
      chk("abort_led_after", int'(LED), 0);
      idle(22);

      // LED duty over the first period for solid, fast and double flash
      for (int j = 0; j < 3; j++) begin
         req = 4'b0001;
         pat = {6'b0, codes[j]};
         wait_grant(60, g);
         hi = 0;
         for (int c = 0; c < 16; c++) begin
            hi += int'(LED);
            @(negedge clk);
         end
         chk("pat_hi", hi, hi_exp[j]);
         req = 4'b0;
         idle(22);
      end

      // Spacing between back-to-back grants
      req = 4'b0001;
      pat = 8'b0;
      wait_grant(60, g);
      n = 0;
      while (gnt != 4'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("gap_done", int'(done), 1);
      n = 0; lowc = 0;
      while (gnt == 4'b0 && n < 40) begin
         if (LED == 1'b0) lowc++;
         @(negedge clk);
         n++;
      end
      chk("gap_dist", n, GAPC + 1);
      chk("gap_led_low", lowc, GAPC + 1);
      chk("gap_regrant", int'(gnt), 1);
      req = 4'b0;
      idle(22);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
